// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte bus responder with a byte RAM, UART TX/RX FIFOs, a cycle counter and a halt register.
// Define TX_OVERFLOW_FLAG_EN to add the sticky tx_overflow output, which flags TX bytes dropped on a full FIFO.
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_PTR_WIDTH  = 4,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_PTR_WIDTH  = 4,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_full,
`ifdef TX_OVERFLOW_FLAG_EN
    output logic        tx_overflow,
`endif
    output logic        program_halt
);
    localparam logic [TX_PTR_WIDTH:0] TX_FULL = (TX_PTR_WIDTH+1)'(TX_FIFO_DEPTH);
    localparam logic [TX_PTR_WIDTH:0] TX_NEAR = (TX_PTR_WIDTH+1)'(TX_FIFO_DEPTH - 2);
    localparam logic [RX_PTR_WIDTH:0] RX_FULL = (RX_PTR_WIDTH+1)'(RX_FIFO_DEPTH);

    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] tx_mem [0:TX_FIFO_DEPTH-1];
    logic [7:0] rx_mem [0:RX_FIFO_DEPTH-1];

    logic [TX_PTR_WIDTH-1:0] tx_wptr, tx_rptr;
    logic [TX_PTR_WIDTH:0]   tx_count, tx_count_next;
    logic [RX_PTR_WIDTH-1:0] rx_wptr, rx_rptr;
    logic [RX_PTR_WIDTH:0]   rx_count;
    logic [31:0]             counter, snapshot;
    logic                    halt_pending;

    logic [ADDR_WIDTH-1:0] ram_idx;
    logic       io, io_rd, io_wr;
    logic       sel_data, sel_cnt, sel_b1, sel_b2, sel_b3;
    logic       tx_pop, tx_space, cpu_push_req, cpu_push, halt_push, tx_push, halt_wr;
    logic       rx_pop, rx_push;
    logic [7:0] rx_head, io_rdata;
    logic       unused_a;

    assign unused_a = ^cpu_a[31:18];
    assign ram_idx  = cpu_a[ADDR_WIDTH-1:0];
    assign io       = cpu_a[17:16] == 2'b11;
    assign io_rd    = io & ~cpu_wr;
    assign io_wr    = io & cpu_wr;
    assign sel_data = cpu_a[17:0] == 18'h30000;
    assign sel_cnt  = cpu_a[17:0] == 18'h30004;
    assign sel_b1   = cpu_a[17:0] == 18'h30005;
    assign sel_b2   = cpu_a[17:0] == 18'h30006;
    assign sel_b3   = cpu_a[17:0] == 18'h30007;

    assign tx_valid = tx_count != '0;
    assign tx_data  = tx_valid ? tx_mem[tx_rptr] : 8'h00;
    assign rx_full  = rx_count == RX_FULL;

    // A pop in the same cycle frees the slot a full FIFO needs for a push.
    assign tx_pop        = tx_valid & tx_ready;
    assign tx_space      = (tx_count != TX_FULL) | tx_pop;
    assign cpu_push_req  = io_wr & sel_data & (cpu_wdata != 8'h00);
    assign cpu_push      = cpu_push_req & tx_space;
    assign halt_push     = halt_pending & ~cpu_push_req & tx_space;
    assign tx_push       = cpu_push | halt_push;
    assign halt_wr       = io_wr & sel_cnt & ~halt_pending & ~program_halt;
    assign tx_count_next = tx_count + (TX_PTR_WIDTH+1)'(tx_push) - (TX_PTR_WIDTH+1)'(tx_pop);

    assign rx_pop   = io_rd & sel_data & (rx_count != '0);
    assign rx_push  = rx_valid & (~rx_full | rx_pop);
    assign rx_head  = (rx_count != '0) ? rx_mem[rx_rptr] : 8'h00;
    assign io_rdata = sel_data ? rx_head :
                      sel_cnt  ? counter[7:0] :
                      sel_b1   ? snapshot[15:8] :
                      sel_b2   ? snapshot[23:16] :
                      sel_b3   ? snapshot[31:24] : 8'h00;

    always_ff @(posedge clk_in) begin
        if (cpu_wr && !io) mem[ram_idx] <= cpu_wdata;
        if (tx_push) tx_mem[tx_wptr] <= cpu_push ? cpu_wdata : 8'h00;
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cpu_rdata      <= 8'h00;
            io_buffer_full <= 1'b0;
            tx_wptr        <= '0;
            tx_rptr        <= '0;
            tx_count       <= '0;
            rx_wptr        <= '0;
            rx_rptr        <= '0;
            rx_count       <= '0;
            counter        <= '0;
            snapshot       <= '0;
            halt_pending   <= 1'b0;
            program_halt   <= 1'b0;
        end else begin
            if (!cpu_wr) cpu_rdata <= io ? io_rdata : mem[ram_idx];
            if (io_rd && sel_cnt) snapshot <= counter;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
            tx_count       <= tx_count_next;
            io_buffer_full <= tx_count_next >= TX_NEAR;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
            rx_count       <= rx_count + (RX_PTR_WIDTH+1)'(rx_push) - (RX_PTR_WIDTH+1)'(rx_pop);
            halt_pending   <= halt_wr | (halt_pending & ~halt_push);
            program_halt   <= program_halt | halt_push;
            counter        <= program_halt ? counter : counter + 32'd1;
        end
    end

`ifdef TX_OVERFLOW_FLAG_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tx_overflow <= 1'b0;
        else tx_overflow <= tx_overflow | (cpu_push_req & ~tx_space);
    end
`endif
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized self-checking bench for mem_io_responder with a queue-based reference model.
module tb_mem_io_responder;
    localparam logic [31:0] IDLE = 32'h0000_0100;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cpu_a = IDLE;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_full;
    logic        program_halt;
`ifdef TX_OVERFLOW_FLAG_EN
    logic        tx_overflow;
    bit          m_ovf;
`endif

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
`ifdef TX_OVERFLOW_FLAG_EN
        .tx_overflow(tx_overflow),
`endif
        .program_halt(program_halt)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: behaviour expressed as queues and counters.
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [7:0]  seen [$];
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_rdata;
    bit          m_pend, m_halt;

    task automatic tick();
        logic [17:0] a;
        logic [7:0]  nrd;
        bit          io, old_pend, halt_now;
        a = cpu_a[17:0];
        io = a[17:16] == 2'b11;
        nrd = m_rdata;
        old_pend = m_pend;
        halt_now = 0;
        if (tx_valid && tx_ready) seen.push_back(tx_data);
        if (!cpu_wr && !io) nrd = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
        else if (!cpu_wr) begin
            nrd = 8'h00;
            if (a == 18'h30000 && rxq.size() > 0) nrd = rxq.pop_front();
            if (a == 18'h30004) begin m_snap = m_cnt; nrd = m_cnt[7:0]; end
            if (a == 18'h30005) nrd = m_snap[15:8];
            if (a == 18'h30006) nrd = m_snap[23:16];
            if (a == 18'h30007) nrd = m_snap[31:24];
        end
        if (cpu_wr && !io) ram_m[int'(a[16:0])] = cpu_wdata;
        if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
        if (cpu_wr && a == 18'h30000 && cpu_wdata != 0) begin
            if (txq.size() < 16) txq.push_back(cpu_wdata);
`ifdef TX_OVERFLOW_FLAG_EN
            else m_ovf = 1;
`endif
        end else if (m_pend && txq.size() < 16) begin
            txq.push_back(8'h00);
            m_pend = 0;
            halt_now = 1;
        end
        if (cpu_wr && a == 18'h30004 && !old_pend && !m_halt) m_pend = 1;
        if (rx_valid && rxq.size() < 16) rxq.push_back(rx_data);
        if (!m_halt) m_cnt = m_cnt + 1;
        m_halt = m_halt | halt_now;
        @(posedge clk_in);
        #1;
        m_rdata = nrd;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_wr = 1; cpu_wdata = d;
        tick();
        cpu_a = IDLE; cpu_wr = 0; cpu_wdata = 0;
    endtask

    task automatic rd(input logic [31:0] a);
        cpu_a = a; cpu_wr = 0;
        tick();
        cpu_a = IDLE;
    endtask

    task automatic do_reset();
        cpu_a = IDLE; cpu_wr = 0; cpu_wdata = 0; rx_valid = 0; tx_ready = 0;
        rst_in = 0;
        #3;
        txq.delete(); rxq.delete(); seen.delete();
        m_cnt = 0; m_snap = 0; m_rdata = 0; m_pend = 0; m_halt = 0;
`ifdef TX_OVERFLOW_FLAG_EN
        m_ovf = 0;
`endif
        @(posedge clk_in);
        #1;
        rst_in = 1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({cpu_rdata, io_buffer_full, tx_valid, tx_data, rx_full, program_halt} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {cpu_rdata, io_buffer_full, tx_valid, tx_data, rx_full, program_halt});
        end
        do_reset();
        tick();
        tests++;
        if ({tx_valid, rx_full, program_halt, io_buffer_full} !== 4'h0) begin
            fails++;
            $display("FAIL post_reset_flags: got %b expected 0000", {tx_valid, rx_full, program_halt, io_buffer_full});
        end
    endtask

    task automatic test_ram();
        logic [16:0] addr [8];
        logic [7:0]  data [8];
        wr(32'h100, 8'hA5);
        rd(32'h100);
        tests++;
        if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL ram_a5: got %h expected a5", cpu_rdata); end
        wr(32'h200, 8'h5A);
        tests++;
        if (cpu_rdata !== 8'hA5) begin fails++; $display("FAIL rdata_hold: got %h expected a5", cpu_rdata); end
        for (int i = 0; i < 8; i++) begin
            addr[i] = 17'($urandom_range(0, 17'h1FFFF));
            data[i] = 8'($urandom);
            wr({15'h0, addr[i]}, data[i]);
        end
        for (int i = 7; i >= 0; i--) begin
            rd({15'h0, addr[i]});
            tests++;
            if (cpu_rdata !== m_rdata) begin
                fails++;
                $display("FAIL ram_rand[%0d] addr %h: got %h expected %h", i, addr[i], cpu_rdata, m_rdata);
            end
        end
    endtask

    task automatic test_tx_order();
        logic [7:0] exp [$];
        logic [7:0] b;
        tx_ready = 1;
        seen.delete();
        wr(32'h30000, 8'h41);
        wr(32'h30000, 8'h00);
        wr(32'h30000, 8'h42);
        repeat (3) tick();
        tests++;
        if (seen.size() != 2 || seen[0] !== 8'h41 || seen[1] !== 8'h42) begin
            fails++;
            $display("FAIL tx_order: got %0d bytes %p expected 41 42", seen.size(), seen);
        end
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (b != 0) exp.push_back(b);
            wr(32'h30000, b);
        end
        repeat (3) tick();
        tests++;
        if (seen != exp) begin
            fails++;
            $display("FAIL tx_rand_order: got %p expected %p", seen, exp);
        end
        tx_ready = 0;
    endtask

    task automatic test_tx_full();
        logic [7:0] sent [$];
        int n;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            sent.push_back(8'($urandom_range(1, 255)));
            wr(32'h30000, sent[k-1]);
            tests++;
            if (io_buffer_full !== (k >= 14)) begin
                fails++;
                $display("FAIL io_buffer_full after write %0d: got %b expected %b", k, io_buffer_full, k >= 14);
            end
        end
`ifdef TX_OVERFLOW_FLAG_EN
        tests++;
        if (tx_overflow !== 1'b1) begin fails++; $display("FAIL tx_overflow: got %b expected 1", tx_overflow); end
`endif
        tx_ready = 1;
        seen.delete();
        n = 0;
        while (tx_valid && n < 40) begin tick(); n++; end
        tests++;
        if (n >= 40) begin fails++; $display("FAIL tx_drain_timeout: got %0d cycles expected < 40", n); end
        sent.pop_back();
        tests++;
        if (seen != sent) begin
            fails++;
            $display("FAIL tx_drain: got %0d bytes %p expected %0d bytes %p", seen.size(), seen, sent.size(), sent);
        end
        tx_ready = 0;
    endtask

    task automatic test_counter();
        logic [31:0] v;
        do_reset();
        repeat (300) tick();
        rd(32'h30004); v[7:0] = cpu_rdata;
        rd(32'h30005); v[15:8] = cpu_rdata;
        rd(32'h30006); v[23:16] = cpu_rdata;
        rd(32'h30007); v[31:24] = cpu_rdata;
        tests++;
        if (v !== 32'd300) begin fails++; $display("FAIL counter_snapshot: got %0d expected 300", v); end
        rd(32'h30008);
        tests++;
        if (cpu_rdata !== 8'h00) begin fails++; $display("FAIL io_other_read: got %h expected 00", cpu_rdata); end
    endtask

    task automatic test_rx();
        logic [7:0] exp [$];
        do_reset();
        rx_valid = 1; rx_data = 8'h33;
        tick();
        rx_valid = 0;
        rd(32'h30000);
        tests++;
        if (cpu_rdata !== 8'h33) begin fails++; $display("FAIL rx_first: got %h expected 33", cpu_rdata); end
        rd(32'h30000);
        tests++;
        if (cpu_rdata !== 8'h00) begin fails++; $display("FAIL rx_empty: got %h expected 00", cpu_rdata); end
        for (int i = 0; i < 18; i++) begin
            rx_valid = 1; rx_data = 8'($urandom);
            if (i < 16) exp.push_back(rx_data);
            tick();
        end
        tests++;
        if (rx_full !== 1'b1) begin fails++; $display("FAIL rx_full: got %b expected 1", rx_full); end
        rx_data = 8'($urandom);
        cpu_a = 32'h30000;
        tick();
        cpu_a = IDLE; rx_valid = 0;
        tests++;
        if (cpu_rdata !== exp[0] || rx_full !== 1'b1) begin
            fails++;
            $display("FAIL rx_pop_push_full: got %h/%b expected %h/1", cpu_rdata, rx_full, exp[0]);
        end
        void'(exp.pop_front());
        exp.push_back(rx_data);
        for (int i = 0; i < 16; i++) begin
            rd(32'h30000);
            tests++;
            if (cpu_rdata !== exp[i]) begin fails++; $display("FAIL rx_read[%0d]: got %h expected %h", i, cpu_rdata, exp[i]); end
        end
        tests++;
        if (rx_full !== 1'b0 || rxq.size() != 0) begin fails++; $display("FAIL rx_drained: got %b expected 0", rx_full); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c0;
        do_reset();
        wr(32'h30004, 8'h01);
        wr(32'h30000, 8'h55);
        tests++;
        if (program_halt !== 1'b0) begin fails++; $display("FAIL halt_priority: got %b expected 0", program_halt); end
        tick();
        tests++;
        if (program_halt !== 1'b1) begin fails++; $display("FAIL halt_retry: got %b expected 1", program_halt); end
        rd(32'h30004); c0 = cpu_rdata;
        repeat (5) tick();
        rd(32'h30004);
        tests++;
        if (cpu_rdata !== c0 || cpu_rdata !== m_rdata) begin
            fails++;
            $display("FAIL counter_frozen: got %h expected %h", cpu_rdata, c0);
        end
        tx_ready = 1;
        seen.delete();
        repeat (4) tick();
        tests++;
        if (seen.size() != 2 || seen[0] !== 8'h55 || seen[1] !== 8'h00) begin
            fails++;
            $display("FAIL b2b_tx_order: got %p expected 55 00", seen);
        end
        tx_ready = 0;
    endtask

    task automatic test_halt();
        int zeros;
        do_reset();
        for (int i = 0; i < 16; i++) wr(32'h30000, 8'($urandom_range(1, 255)));
        wr(32'h30004, 8'h01);
        repeat (5) tick();
        tests++;
        if (program_halt !== 1'b0) begin fails++; $display("FAIL halt_blocked: got %b expected 0", program_halt); end
        tx_ready = 1;
        seen.delete();
        tick();
        tx_ready = 0;
        tests++;
        if (program_halt !== 1'b1) begin fails++; $display("FAIL halt_set: got %b expected 1", program_halt); end
        tests++;
        if (io_buffer_full !== (txq.size() >= 14) || tx_data !== txq[0]) begin
            fails++;
            $display("FAIL halt_tx_state: got %b/%h expected %b/%h", io_buffer_full, tx_data, txq.size() >= 14, txq[0]);
        end
        wr(32'h30004, 8'h01);
        tx_ready = 1;
        repeat (20) tick();
        zeros = 0;
        foreach (seen[i]) if (seen[i] == 8'h00) zeros++;
        tests++;
        if (seen.size() != 17 || seen[16] !== 8'h00 || zeros != 1) begin
            fails++;
            $display("FAIL halt_push_once: got %0d bytes %0d zeros expected 17 bytes 1 zero", seen.size(), zeros);
        end
        tx_ready = 0;
        wr(32'h30000, 8'h77);
        rd(32'h30004);
        rst_in = 0;
        #2;
        tests++;
        if ({cpu_rdata, io_buffer_full, tx_valid, tx_data, rx_full, program_halt} !== 20'h0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0", {cpu_rdata, io_buffer_full, tx_valid, tx_data, rx_full, program_halt});
        end
`ifdef TX_OVERFLOW_FLAG_EN
        tests++;
        if (tx_overflow !== 1'b0) begin fails++; $display("FAIL async_reset_ovf: got %b expected 0", tx_overflow); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_order();
        test_tx_full();
        test_counter();
        test_rx();
        test_back_to_back();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
